// File: rtl/write_back_buffer_pkg.sv
// Shared types and constants for the write-back buffer: drain FSM states and
// the line-offset width used to reduce byte addresses to line addresses.
package write_back_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } wbb_state_e;

    function automatic int unsigned line_offset_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Offset bits for the default 512-bit (64-byte) line.
    localparam int unsigned LINE_OFFSET_BITS = line_offset_bits(512);

endpackage

// File: rtl/wbb_fifo.sv
// Line storage for the write-back buffer: circular entries with valid bits and
// wrap-around pointers carrying one extra bit to tell full from empty.
module wbb_fifo
    import write_back_buffer_pkg::*;
#(
    parameter int unsigned AW    = 64,
    parameter int unsigned DW    = 512,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           arstn,
    input  logic                           push_i,
    input  logic [AW-1:0]                  push_addr_i,
    input  logic [DW-1:0]                  push_data_i,
    input  logic                           pop_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [AW-1:0]                  head_addr_o,
    output logic [DW-1:0]                  head_data_o,
    output logic [$clog2(DEPTH)-1:0]       rd_idx_o,
    output logic [DEPTH-1:0]               valid_o,
    output logic [DEPTH-1:0][AW-1:0]       addr_o,
    output logic [DEPTH-1:0][DW-1:0]       data_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]             wr_ptr_q, wr_ptr_d;
    logic [PW:0]             rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;

    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    assign wr_idx  = wr_ptr_q[PW-1:0];
    assign rd_idx  = rd_ptr_q[PW-1:0];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (pop_ok) begin
            valid_d[rd_idx] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            valid_d[wr_idx] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    // Payload is only ever observed through valid bits, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[wr_idx] <= push_addr_i;
            data_q[wr_idx] <= push_data_i;
        end
    end

    assign full_o      = full;
    assign empty_o     = empty;
    assign head_addr_o = addr_q[rd_idx];
    assign head_data_o = data_q[rd_idx];
    assign rd_idx_o    = rd_idx;
    assign valid_o     = valid_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;

endmodule

// File: rtl/write_back_buffer.sv
// Write-back buffer between cache and AXI: queues evicted dirty lines, drains
// them one burst at a time and forwards buffered lines to pending refills.
//
// state | meaning
// IDLE  | no burst in flight; start one when an entry is held
// WRITE | head entry presented to AXI, waiting for the write response
// GAP   | one dead cycle after a response before the next burst
module write_back_buffer
    import write_back_buffer_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned DEPTH          = 2
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic                      i_wb_valid,
    input  logic [AXI_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0]     i_wb_data,
    output logic                      o_wb_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] i_lookup_addr,
    output logic                      o_fwd_hit,
    output logic [DATA_WIDTH-1:0]     o_fwd_data,
    output logic                      o_start_write_axi,
    output logic [AXI_ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0]     o_data_write_axi,
    input  logic                      i_b_resp_axi,
    output logic                      o_empty
);

    localparam int unsigned OFF = line_offset_bits(DATA_WIDTH);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK =
        {{(AXI_ADDR_WIDTH - OFF){1'b1}}, {OFF{1'b0}}};

    wbb_state_e state_q, state_d;

    logic                                 fifo_push;
    logic                                 fifo_pop;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic [AXI_ADDR_WIDTH-1:0]            head_addr;
    logic [DATA_WIDTH-1:0]                head_data;
    logic [PW-1:0]                        rd_idx;
    logic [DEPTH-1:0]                     ent_valid;
    logic [DEPTH-1:0][AXI_ADDR_WIDTH-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]     ent_data;
    logic [PW-1:0]                        fwd_idx;

    wbb_fifo #(
        .AW    (AXI_ADDR_WIDTH),
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .arstn       (arstn),
        .push_i      (fifo_push),
        .push_addr_i (i_wb_addr),
        .push_data_i (i_wb_data),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .rd_idx_o    (rd_idx),
        .valid_o     (ent_valid),
        .addr_o      (ent_addr),
        .data_o      (ent_data)
    );

    // Ready depends on registered fullness only, so a pop never frees a slot
    // for a push in the same cycle.
    assign o_wb_ready = !fifo_full;
    assign fifo_push  = i_wb_valid && o_wb_ready;
    assign o_empty    = fifo_empty;

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = WRITE;
            WRITE:   if (i_b_resp_axi) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_start_write_axi = 1'b0;
        o_addr            = '0;
        o_data_write_axi  = '0;
        fifo_pop          = 1'b0;
        if (state_q == WRITE) begin
            o_start_write_axi = 1'b1;
            o_addr            = head_addr;
            o_data_write_axi  = head_data;
            fifo_pop          = i_b_resp_axi;
        end
    end

    // Walk entries oldest to youngest so the last match is the youngest line.
    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = '0;
        fwd_idx    = '0;
        for (int j = 0; j < DEPTH; j++) begin
            fwd_idx = rd_idx + PW'(j);
            if (ent_valid[fwd_idx] &&
                ((ent_addr[fwd_idx] & LINE_MASK) == (i_lookup_addr & LINE_MASK))) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = ent_data[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_write_back_buffer.sv
// Randomized plus directed bench for write_back_buffer: two instances (DEPTH 2
// and 4) share stimulus and are each checked against a queue-based model.
module tb_write_back_buffer;

    typedef struct packed {
        logic [63:0]  a;
        logic [511:0] d;
    } line_t;

    logic         clk = 1'b0;
    logic         arstn = 1'b0;
    logic         wb_valid = 1'b0;
    logic [63:0]  wb_addr = '0;
    logic [511:0] wb_data = '0;
    logic [63:0]  lookup = '0;
    logic         b_resp = 1'b0;

    logic         rdy   [2];
    logic         hit   [2];
    logic         start [2];
    logic         empty [2];
    logic [63:0]  oaddr [2];
    logic [511:0] fdata [2];
    logic [511:0] wdata [2];

    int    n_checks = 0;
    int    n_pass   = 0;
    bit    mon_en   = 1'b0;
    line_t mq [2][$];
    int    phase [2] = '{0, 0};
    int    depth [2] = '{2, 4};

    always #5 clk = ~clk;

    write_back_buffer #(.AXI_ADDR_WIDTH(64), .DATA_WIDTH(512), .DEPTH(2)) dut0 (
        .clk(clk), .arstn(arstn),
        .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_ready(rdy[0]),
        .i_lookup_addr(lookup), .o_fwd_hit(hit[0]), .o_fwd_data(fdata[0]),
        .o_start_write_axi(start[0]), .o_addr(oaddr[0]), .o_data_write_axi(wdata[0]),
        .i_b_resp_axi(b_resp), .o_empty(empty[0])
    );

    write_back_buffer #(.AXI_ADDR_WIDTH(64), .DATA_WIDTH(512), .DEPTH(4)) dut1 (
        .clk(clk), .arstn(arstn),
        .i_wb_valid(wb_valid), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_ready(rdy[1]),
        .i_lookup_addr(lookup), .o_fwd_hit(hit[1]), .o_fwd_data(fdata[1]),
        .o_start_write_axi(start[1]), .o_addr(oaddr[1]), .o_data_write_axi(wdata[1]),
        .i_b_resp_axi(b_resp), .o_empty(empty[1])
    );

    task automatic chk(input string nm, input int k, input logic [511:0] act,
                       input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    endtask

    // Monitor/model: compare the registered-state view, then apply this edge.
    logic [511:0] e_fd;
    logic         e_hit;
    logic         e_pop;
    logic         e_acc;
    int           n;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                n     = mq[k].size();
                e_hit = 1'b0;
                e_fd  = '0;
                for (int i = 0; i < n; i++) begin
                    if ((mq[k][i].a >> 6) == (lookup >> 6)) begin
                        e_hit = 1'b1;
                        e_fd  = mq[k][i].d;
                    end
                end
                chk("ready", k, 512'(rdy[k]), 512'(n < depth[k]));
                chk("empty", k, 512'(empty[k]), 512'(n == 0));
                chk("start", k, 512'(start[k]), 512'(phase[k] == 1));
                chk("addr", k, 512'(oaddr[k]), (phase[k] == 1 && n > 0) ? 512'(mq[k][0].a) : '0);
                chk("wdata", k, wdata[k], (phase[k] == 1 && n > 0) ? mq[k][0].d : '0);
                chk("fwd_hit", k, 512'(hit[k]), 512'(e_hit));
                chk("fwd_data", k, fdata[k], e_fd);

                if (!arstn) begin
                    mq[k].delete();
                    phase[k] = 0;
                end else begin
                    e_pop = (phase[k] == 1) && b_resp;
                    e_acc = wb_valid && (n < depth[k]);
                    case (phase[k])
                        0: if (n > 0) phase[k] = 1;
                        1: if (b_resp) phase[k] = 2;
                        default: phase[k] = 0;
                    endcase
                    if (e_pop) void'(mq[k].pop_front());
                    if (e_acc) mq[k].push_back('{wb_addr, wb_data});
                end
            end
        end
    end

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        wb_valid = 1'b0;
        b_resp   = 1'b0;
        repeat (cycles) step();
    endtask

    task automatic push(input logic [63:0] a, input logic [511:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        b_resp   = 1'b0;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic resp();
        b_resp = 1'b1;
        step();
        b_resp = 1'b0;
    endtask

    task automatic do_reset();
        arstn    = 1'b0;
        wb_valid = 1'b0;
        b_resp   = 1'b0;
        step();
        arstn = 1'b1;
    endtask

    task automatic wait_start(input int k);
        bit seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (start[k]) seen = 1'b1;
            else step();
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL wait_start inst%0d: got no burst request expected one within 30 cycles", k);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        arstn  = 1'b1;
        mon_en = 1'b1;

        // Single line drains, then buffer reports empty.
        lookup = 64'h1000;
        push(64'h1000, rand512());
        idle(6);
        resp();
        idle(4);

        // Fill DEPTH=2, extra push refused until a response frees a slot.
        do_reset();
        push(64'h1000, rand512());
        push(64'h2000, rand512());
        wb_valid = 1'b1;
        wb_addr  = 64'h3000;
        wb_data  = rand512();
        step();
        step();
        wb_valid = 1'b0;
        wait_start(0);
        idle(2);
        resp();
        idle(3);

        // Same line pushed twice: youngest data forwarded until both drain.
        do_reset();
        lookup = 64'h1020;
        push(64'h1000, rand512());
        push(64'h1000, rand512());
        wait_start(0);
        idle(1);
        resp();
        wait_start(0);
        resp();
        idle(3);

        // Responses outside WRITE are ignored.
        do_reset();
        resp();
        push(64'h6000, rand512());
        resp();
        wait_start(0);
        b_resp = 1'b1;
        step();
        step();
        b_resp = 1'b0;
        idle(4);

        // Reset in the middle of a burst with two entries held.
        do_reset();
        push(64'h4000, rand512());
        push(64'h5000, rand512());
        wait_start(0);
        idle(1);
        lookup = 64'h4000;
        do_reset();
        idle(2);
        resp();
        idle(2);

        // Four lines through DEPTH=4: pointers wrap, drain in push order.
        do_reset();
        for (int i = 0; i < 4; i++) push(64'h8000 + 64'(i) * 64'h1000, rand512());
        for (int i = 0; i < 4; i++) begin
            wait_start(1);
            idle(1);
            resp();
            idle(2);
        end
        for (int i = 0; i < 3; i++) push(64'hC000 + 64'(i) * 64'h40, rand512());
        for (int i = 0; i < 3; i++) begin
            wait_start(1);
            resp();
        end
        idle(3);

        // Random traffic over a small set of lines to provoke forwarding hits.
        for (int c = 0; c < 3000; c++) begin
            arstn    = ($urandom_range(0, 299) != 0);
            wb_valid = $urandom_range(0, 1) == 1;
            wb_addr  = (64'($urandom_range(0, 7)) << 6) | 64'($urandom_range(0, 63));
            wb_data  = rand512();
            lookup   = (64'($urandom_range(0, 7)) << 6) | 64'($urandom_range(0, 63));
            b_resp   = $urandom_range(0, 2) == 0;
            step();
        end
        arstn = 1'b1;
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
